// File: rtl/dis_grt_responder.sv
// Resource-table responder: one update slot per table group, per-CU wavefront counters,
// and a round-robin done arbiter that returns at most one alloc/dealloc completion per cycle.
module dis_grt_responder #(
   parameter int NUMBER_CU            = 64,
   parameter int CU_ID_WIDTH          = 6,
   parameter int RES_TABLE_ADDR_WIDTH = 1,
   parameter int WG_ID_WIDTH          = 15,
   parameter int WF_COUNT_WIDTH       = 6,
   parameter int MAX_WF_PER_CU        = 40,
   parameter int UPDATE_LATENCY       = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      dis_controller_wg_alloc_valid,
   input  logic [CU_ID_WIDTH-1:0]                    alloc_cu_id,
   input  logic [WG_ID_WIDTH-1:0]                    alloc_wgid,
   input  logic [WF_COUNT_WIDTH-1:0]                 alloc_wf_count,
   input  logic                                      dis_controller_wg_dealloc_valid,
   input  logic [CU_ID_WIDTH-1:0]                    dealloc_cu_id,
   input  logic [WG_ID_WIDTH-1:0]                    dealloc_wgid,
   input  logic [WF_COUNT_WIDTH-1:0]                 dealloc_wf_count,
   input  logic [CU_ID_WIDTH-1:0]                    rd_cu_id,
   output logic [WF_COUNT_WIDTH-1:0]                 rd_wf_count,
   output logic                                      grt_wg_alloc_done,
   output logic [WG_ID_WIDTH-1:0]                    grt_wg_alloc_wgid,
   output logic [CU_ID_WIDTH-1:0]                    grt_wg_alloc_cu_id,
   output logic                                      grt_wg_dealloc_done,
   output logic [WG_ID_WIDTH-1:0]                    grt_wg_dealloc_wgid,
   output logic [CU_ID_WIDTH-1:0]                    grt_wg_dealloc_cu_id,
   output logic                                      grt_protocol_err,
   output logic [2*(2**RES_TABLE_ADDR_WIDTH)-1:0]    dbg_slot_state
);

   localparam int NUM_GROUPS = 2**RES_TABLE_ADDR_WIDTH;
   localparam int GW         = RES_TABLE_ADDR_WIDTH;
   localparam int TW         = (UPDATE_LATENCY > 1) ? $clog2(UPDATE_LATENCY) : 1;
   localparam int CW         = WF_COUNT_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_BUSY      = 2'd1,
      S_DONE_PEND = 2'd2
   } slot_state_e;

   // Command handshake: each valid is a single-cycle pulse with no ready; a command is
   // taken only when its group slot is IDLE, otherwise it is dropped and flagged.
   slot_state_e               state_q    [NUM_GROUPS];
   slot_state_e               state_d    [NUM_GROUPS];
   logic                      is_alloc_q [NUM_GROUPS];
   logic                      is_alloc_d [NUM_GROUPS];
   logic [CU_ID_WIDTH-1:0]    cu_q       [NUM_GROUPS];
   logic [CU_ID_WIDTH-1:0]    cu_d       [NUM_GROUPS];
   logic [WG_ID_WIDTH-1:0]    wgid_q     [NUM_GROUPS];
   logic [WG_ID_WIDTH-1:0]    wgid_d     [NUM_GROUPS];
   logic [WF_COUNT_WIDTH-1:0] wf_q       [NUM_GROUPS];
   logic [WF_COUNT_WIDTH-1:0] wf_d       [NUM_GROUPS];
   logic [TW-1:0]             timer_q    [NUM_GROUPS];
   logic [TW-1:0]             timer_d    [NUM_GROUPS];

   logic [WF_COUNT_WIDTH-1:0] cnt_q      [NUMBER_CU];
   logic [WF_COUNT_WIDTH-1:0] cnt_d      [NUMBER_CU];

   logic [GW-1:0]             ptr_q, ptr_d;
   logic                      err_q, err_d;
   logic [WF_COUNT_WIDTH-1:0] rd_q, rd_d;
   logic                      alloc_done_q, alloc_done_d;
   logic [WG_ID_WIDTH-1:0]    alloc_wgid_q, alloc_wgid_d;
   logic [CU_ID_WIDTH-1:0]    alloc_cu_q, alloc_cu_d;
   logic                      dealloc_done_q, dealloc_done_d;
   logic [WG_ID_WIDTH-1:0]    dealloc_wgid_q, dealloc_wgid_d;
   logic [CU_ID_WIDTH-1:0]    dealloc_cu_q, dealloc_cu_d;

   logic                      grant_found;
   logic [GW-1:0]             grant_idx;
   logic [GW-1:0]             cand;
   logic [CW-1:0]             cur_cnt;
   logic [CW-1:0]             new_cnt;
   logic [GW-1:0]             alloc_grp;
   logic [GW-1:0]             dealloc_grp;

   assign alloc_grp   = alloc_cu_id[CU_ID_WIDTH-1 -: GW];
   assign dealloc_grp = dealloc_cu_id[CU_ID_WIDTH-1 -: GW];

   always_comb begin
      state_d        = state_q;
      is_alloc_d     = is_alloc_q;
      cu_d           = cu_q;
      wgid_d         = wgid_q;
      wf_d           = wf_q;
      timer_d        = timer_q;
      cnt_d          = cnt_q;
      ptr_d          = ptr_q;
      err_d          = err_q;
      rd_d           = cnt_q[rd_cu_id];
      alloc_done_d   = 1'b0;
      alloc_wgid_d   = alloc_wgid_q;
      alloc_cu_d     = alloc_cu_q;
      dealloc_done_d = 1'b0;
      dealloc_wgid_d = dealloc_wgid_q;
      dealloc_cu_d   = dealloc_cu_q;
      grant_found    = 1'b0;
      grant_idx      = '0;
      cand           = '0;
      cur_cnt        = '0;
      new_cnt        = '0;

      // Round-robin search for a pending done, starting at the pointer.
      for (int i = 0; i < NUM_GROUPS; i++) begin
         cand = ptr_q + GW'(i);
         if (!grant_found && state_q[cand] == S_DONE_PEND) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end

      if (grant_found) begin
         state_d[grant_idx] = S_IDLE;
         ptr_d              = grant_idx + GW'(1);
         if (is_alloc_q[grant_idx]) begin
            alloc_done_d = 1'b1;
            alloc_wgid_d = wgid_q[grant_idx];
            alloc_cu_d   = cu_q[grant_idx];
         end else begin
            dealloc_done_d = 1'b1;
            dealloc_wgid_d = wgid_q[grant_idx];
            dealloc_cu_d   = cu_q[grant_idx];
         end
      end

      // Groups own disjoint CU ranges, so concurrent writes never hit the same counter.
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if (state_q[g] == S_BUSY) begin
            if (timer_q[g] == '0) begin
               state_d[g] = S_DONE_PEND;
               cur_cnt    = {1'b0, cnt_q[cu_q[g]]};
               if (is_alloc_q[g]) begin
                  new_cnt = cur_cnt + {1'b0, wf_q[g]};
                  if (new_cnt > CW'(MAX_WF_PER_CU)) begin
                     new_cnt = CW'(MAX_WF_PER_CU);
                     err_d   = 1'b1;
                  end
               end else begin
                  new_cnt = cur_cnt - {1'b0, wf_q[g]};
                  if (new_cnt[CW-1]) begin
                     new_cnt = '0;
                     err_d   = 1'b1;
                  end
               end
               cnt_d[cu_q[g]] = new_cnt[WF_COUNT_WIDTH-1:0];
            end else begin
               timer_d[g] = timer_q[g] - 1'b1;
            end
         end
      end

      // A slot being granted this edge is not yet IDLE, so a command aimed at it is dropped.
      if (dis_controller_wg_dealloc_valid) begin
         if (dis_controller_wg_alloc_valid) begin
            err_d = 1'b1;
         end
         if (state_q[dealloc_grp] == S_IDLE) begin
            state_d[dealloc_grp]    = S_BUSY;
            is_alloc_d[dealloc_grp] = 1'b0;
            cu_d[dealloc_grp]       = dealloc_cu_id;
            wgid_d[dealloc_grp]     = dealloc_wgid;
            wf_d[dealloc_grp]       = dealloc_wf_count;
            timer_d[dealloc_grp]    = TW'(UPDATE_LATENCY - 1);
         end else begin
            err_d = 1'b1;
         end
      end else if (dis_controller_wg_alloc_valid) begin
         if (state_q[alloc_grp] == S_IDLE) begin
            state_d[alloc_grp]    = S_BUSY;
            is_alloc_d[alloc_grp] = 1'b1;
            cu_d[alloc_grp]       = alloc_cu_id;
            wgid_d[alloc_grp]     = alloc_wgid;
            wf_d[alloc_grp]       = alloc_wf_count;
            timer_d[alloc_grp]    = TW'(UPDATE_LATENCY - 1);
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < NUM_GROUPS; g++) begin
            state_q[g]    <= S_IDLE;
            is_alloc_q[g] <= 1'b0;
            cu_q[g]       <= '0;
            wgid_q[g]     <= '0;
            wf_q[g]       <= '0;
            timer_q[g]    <= '0;
         end
         for (int c = 0; c < NUMBER_CU; c++) begin
            cnt_q[c] <= '0;
         end
         ptr_q          <= '0;
         err_q          <= 1'b0;
         rd_q           <= '0;
         alloc_done_q   <= 1'b0;
         alloc_wgid_q   <= '0;
         alloc_cu_q     <= '0;
         dealloc_done_q <= 1'b0;
         dealloc_wgid_q <= '0;
         dealloc_cu_q   <= '0;
      end else begin
         state_q        <= state_d;
         is_alloc_q     <= is_alloc_d;
         cu_q           <= cu_d;
         wgid_q         <= wgid_d;
         wf_q           <= wf_d;
         timer_q        <= timer_d;
         cnt_q          <= cnt_d;
         ptr_q          <= ptr_d;
         err_q          <= err_d;
         rd_q           <= rd_d;
         alloc_done_q   <= alloc_done_d;
         alloc_wgid_q   <= alloc_wgid_d;
         alloc_cu_q     <= alloc_cu_d;
         dealloc_done_q <= dealloc_done_d;
         dealloc_wgid_q <= dealloc_wgid_d;
         dealloc_cu_q   <= dealloc_cu_d;
      end
   end

   assign rd_wf_count          = rd_q;
   assign grt_wg_alloc_done    = alloc_done_q;
   assign grt_wg_alloc_wgid    = alloc_wgid_q;
   assign grt_wg_alloc_cu_id   = alloc_cu_q;
   assign grt_wg_dealloc_done  = dealloc_done_q;
   assign grt_wg_dealloc_wgid  = dealloc_wgid_q;
   assign grt_wg_dealloc_cu_id = dealloc_cu_q;
   assign grt_protocol_err     = err_q;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_dbg
      assign dbg_slot_state[2*g +: 2] = state_q[g];
   end

endmodule

// File: tb/tb_dis_grt_responder.sv
// Bench for dis_grt_responder: directed scenarios with literal expectations, then random
// traffic checked every cycle against a timestamp-based model of the resource table.
`timescale 1ns/1ps
module tb_dis_grt_responder;

   localparam int CUW      = 6;
   localparam int WGW      = 15;
   localparam int WFW      = 6;
   localparam int NCU      = 64;
   localparam int NG       = 2;
   localparam int LAT      = 3;
   localparam int MAXWF    = 40;
   localparam int CU_PER_G = NCU / NG;
   localparam int QW       = 1 + WGW + CUW;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             alloc_valid = 1'b0;
   logic [CUW-1:0]   alloc_cu_id = '0;
   logic [WGW-1:0]   alloc_wgid = '0;
   logic [WFW-1:0]   alloc_wf_count = '0;
   logic             dealloc_valid = 1'b0;
   logic [CUW-1:0]   dealloc_cu_id = '0;
   logic [WGW-1:0]   dealloc_wgid = '0;
   logic [WFW-1:0]   dealloc_wf_count = '0;
   logic [CUW-1:0]   rd_cu_id = '0;
   logic [WFW-1:0]   rd_wf_count;
   logic             grt_wg_alloc_done;
   logic [WGW-1:0]   grt_wg_alloc_wgid;
   logic [CUW-1:0]   grt_wg_alloc_cu_id;
   logic             grt_wg_dealloc_done;
   logic [WGW-1:0]   grt_wg_dealloc_wgid;
   logic [CUW-1:0]   grt_wg_dealloc_cu_id;
   logic             grt_protocol_err;
   logic [2*NG-1:0]  dbg_slot_state;

   dis_grt_responder #(
      .NUMBER_CU(NCU), .CU_ID_WIDTH(CUW), .RES_TABLE_ADDR_WIDTH(1), .WG_ID_WIDTH(WGW),
      .WF_COUNT_WIDTH(WFW), .MAX_WF_PER_CU(MAXWF), .UPDATE_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .dis_controller_wg_alloc_valid(alloc_valid), .alloc_cu_id(alloc_cu_id),
      .alloc_wgid(alloc_wgid), .alloc_wf_count(alloc_wf_count),
      .dis_controller_wg_dealloc_valid(dealloc_valid), .dealloc_cu_id(dealloc_cu_id),
      .dealloc_wgid(dealloc_wgid), .dealloc_wf_count(dealloc_wf_count),
      .rd_cu_id(rd_cu_id), .rd_wf_count(rd_wf_count),
      .grt_wg_alloc_done(grt_wg_alloc_done), .grt_wg_alloc_wgid(grt_wg_alloc_wgid),
      .grt_wg_alloc_cu_id(grt_wg_alloc_cu_id),
      .grt_wg_dealloc_done(grt_wg_dealloc_done), .grt_wg_dealloc_wgid(grt_wg_dealloc_wgid),
      .grt_wg_dealloc_cu_id(grt_wg_dealloc_cu_id),
      .grt_protocol_err(grt_protocol_err), .dbg_slot_state(dbg_slot_state)
   );

   int n_cmp = 0;
   int n_fail = 0;
   logic [QW-1:0] exp_q[$];

   // Model: each accepted op is a timestamp; it writes LAT edges after acceptance and
   // may be reported on any later edge, one report per edge, round-robin by group.
   int m_cnt   [NCU];
   bit m_busy  [NG];
   int m_wr    [NG];
   bit m_alloc [NG];
   int m_cu    [NG];
   int m_wgid  [NG];
   int m_wf    [NG];
   int m_ptr;
   bit m_err;
   int edge_n = 0;
   bit e_ad, e_dd;
   int e_rd;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < NCU; c++) m_cnt[c] = 0;
      for (int g = 0; g < NG; g++) m_busy[g] = 0;
      m_ptr = 0;
      m_err = 0;
      e_ad  = 0;
      e_dd  = 0;
      e_rd  = 0;
      exp_q.delete();
   endtask

   task automatic model_edge(input bit av, input int acu, input int awg, input int awf,
                             input bit dv, input int dcu, input int dwg, input int dwf,
                             input int rcu);
      bit busy_pre [NG];
      int gsel;
      int v;
      int g;
      busy_pre = m_busy;
      e_rd = m_cnt[rcu];
      gsel = -1;
      for (int i = 0; i < NG; i++) begin
         g = (m_ptr + i) % NG;
         if (gsel < 0 && m_busy[g] && edge_n > m_wr[g]) gsel = g;
      end
      e_ad = 0;
      e_dd = 0;
      if (gsel >= 0) begin
         if (m_alloc[gsel]) e_ad = 1; else e_dd = 1;
         exp_q.push_back({m_alloc[gsel], WGW'(m_wgid[gsel]), CUW'(m_cu[gsel])});
         m_busy[gsel] = 0;
         m_ptr = (gsel + 1) % NG;
      end
      for (int k = 0; k < NG; k++) begin
         if (m_busy[k] && m_wr[k] == edge_n) begin
            v = m_alloc[k] ? m_cnt[m_cu[k]] + m_wf[k] : m_cnt[m_cu[k]] - m_wf[k];
            if (v > MAXWF) begin v = MAXWF; m_err = 1; end
            if (v < 0) begin v = 0; m_err = 1; end
            m_cnt[m_cu[k]] = v;
         end
      end
      if (av && dv) m_err = 1;
      if (dv || av) begin
         g = dv ? dcu / CU_PER_G : acu / CU_PER_G;
         if (busy_pre[g]) m_err = 1;
         else begin
            m_busy[g]  = 1;
            m_wr[g]    = edge_n + LAT;
            m_alloc[g] = !dv;
            m_cu[g]    = dv ? dcu : acu;
            m_wgid[g]  = dv ? dwg : awg;
            m_wf[g]    = dv ? dwf : awf;
         end
      end
   endtask

   // scoreboard: compared after every edge
   task automatic compare();
      logic [QW-1:0] exp_id;
      logic [QW-1:0] act_id;
      check("alloc_done", grt_wg_alloc_done, e_ad);
      check("dealloc_done", grt_wg_dealloc_done, e_dd);
      check("rd_wf_count", rd_wf_count, e_rd);
      check("protocol_err", grt_protocol_err, m_err);
      if (e_ad || e_dd) begin
         exp_id = exp_q.pop_front();
         if (grt_wg_alloc_done || grt_wg_dealloc_done) begin
            act_id = grt_wg_alloc_done ? {1'b1, grt_wg_alloc_wgid, grt_wg_alloc_cu_id}
                                       : {1'b0, grt_wg_dealloc_wgid, grt_wg_dealloc_cu_id};
            check("done_id", int'(act_id), int'(exp_id));
         end
      end
   endtask

   // driver
   task automatic tick(input bit av, input int acu, input int awg, input int awf,
                       input bit dv, input int dcu, input int dwg, input int dwf,
                       input int rcu);
      alloc_valid      = av;
      alloc_cu_id      = CUW'(acu);
      alloc_wgid       = WGW'(awg);
      alloc_wf_count   = WFW'(awf);
      dealloc_valid    = dv;
      dealloc_cu_id    = CUW'(dcu);
      dealloc_wgid     = WGW'(dwg);
      dealloc_wf_count = WFW'(dwf);
      rd_cu_id         = CUW'(rcu);
      model_edge(av, acu, awg, awf, dv, dcu, dwg, dwf, rcu);
      @(posedge clk);
      #1;
      compare();
      edge_n++;
   endtask

   task automatic idle(input int rcu);
      tick(0, 0, 0, 0, 0, 0, 0, 0, rcu);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alloc_valid   = 1'b0;
      dealloc_valid = 1'b0;
      #1;
      check("rst_alloc_done", grt_wg_alloc_done, 0);
      check("rst_dealloc_done", grt_wg_dealloc_done, 0);
      check("rst_alloc_wgid", grt_wg_alloc_wgid, 0);
      check("rst_dealloc_cu", grt_wg_dealloc_cu_id, 0);
      check("rst_rd", rd_wf_count, 0);
      check("rst_err", grt_protocol_err, 0);
      check("rst_slot_state", dbg_slot_state, 0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_done(input bit want_alloc, input int rcu, input int t0,
                            output int lat, output int wg, output int cu, output int rd);
      lat = -1; wg = -1; cu = -1; rd = -1;
      for (int i = 0; i < 10 && lat < 0; i++) begin
         idle(rcu);
         if (want_alloc ? grt_wg_alloc_done : grt_wg_dealloc_done) begin
            lat = edge_n - 1 - t0;
            wg  = want_alloc ? int'(grt_wg_alloc_wgid) : int'(grt_wg_dealloc_wgid);
            cu  = want_alloc ? int'(grt_wg_alloc_cu_id) : int'(grt_wg_dealloc_cu_id);
            rd  = rd_wf_count;
         end
      end
   endtask

   initial begin
      int t0, lat, wg, cu, rd;
      int e1, e2;
      bit av, dv;

      do_reset();

      // alloc then matching dealloc on cu 5
      tick(1, 5, 'h12, 4, 0, 0, 0, 0, 5);
      t0 = edge_n - 1;
      wait_done(1, 5, t0, lat, wg, cu, rd);
      check("t1_latency", lat, 4);
      check("t1_wgid", wg, 'h12);
      check("t1_cu", cu, 5);
      check("t1_rd", rd, 4);
      tick(0, 0, 0, 0, 1, 5, 'h12, 4, 5);
      t0 = edge_n - 1;
      wait_done(0, 5, t0, lat, wg, cu, rd);
      check("t2_latency", lat, 4);
      check("t2_cu", cu, 5);
      check("t2_rd", rd, 0);
      check("t2_err", grt_protocol_err, 0);

      // back-to-back allocs on the two groups complete on consecutive cycles
      tick(1, 3, 'h21, 2, 0, 0, 0, 0, 3);
      t0 = edge_n - 1;
      tick(1, 40, 'h22, 6, 0, 0, 0, 0, 40);
      e1 = -1; e2 = -1;
      for (int i = 0; i < 8; i++) begin
         idle(40);
         if (grt_wg_alloc_done && grt_wg_alloc_wgid == WGW'('h21)) e1 = edge_n - 1 - t0;
         if (grt_wg_alloc_done && grt_wg_alloc_wgid == WGW'('h22)) e2 = edge_n - 1 - t0;
      end
      check("t3_first_done", e1, 4);
      check("t3_second_done", e2, 5);

      // saturation both ways
      tick(1, 7, 'h70, 30, 0, 0, 0, 0, 7);
      t0 = edge_n - 1;
      wait_done(1, 7, t0, lat, wg, cu, rd);
      check("t5_rd_30", rd, 30);
      tick(1, 7, 'h71, 30, 0, 0, 0, 0, 7);
      t0 = edge_n - 1;
      wait_done(1, 7, t0, lat, wg, cu, rd);
      check("t5_rd_clamp_hi", rd, 40);
      check("t5_err", grt_protocol_err, 1);
      tick(0, 0, 0, 0, 1, 7, 'h70, 50, 7);
      t0 = edge_n - 1;
      wait_done(0, 7, t0, lat, wg, cu, rd);
      check("t5_rd_clamp_lo", rd, 0);

      // command to a busy slot is dropped
      do_reset();
      tick(1, 10, 1, 3, 0, 0, 0, 0, 10);
      tick(1, 12, 2, 3, 0, 0, 0, 0, 10);
      check("busy_drop_err", grt_protocol_err, 1);
      for (int i = 0; i < 6; i++) idle(12);
      check("busy_drop_rd", rd_wf_count, 0);
      idle(10);
      check("busy_keep_rd", rd_wf_count, 3);

      // reset while busy discards the op; then both valids in one cycle
      do_reset();
      tick(1, 2, 'h5, 5, 0, 0, 0, 0, 2);
      idle(2);
      do_reset();
      for (int i = 0; i < 8; i++) idle(2);
      check("t6_rd_after_rst", rd_wf_count, 0);
      tick(1, 9, 'h33, 3, 1, 40, 'h44, 0, 9);
      t0 = edge_n - 1;
      check("t6_both_err", grt_protocol_err, 1);
      wait_done(0, 9, t0, lat, wg, cu, rd);
      check("t6_dealloc_wgid", wg, 'h44);
      check("t6_dealloc_cu", cu, 40);
      check("t6_alloc_dropped_rd", rd, 0);

      // random traffic on a small CU set in both groups
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int n = 0; n < 600; n++) begin
            av = ($urandom_range(0, 99) < 35);
            dv = ($urandom_range(0, 99) < (r == 0 ? 8 : 20));
            tick(av, $urandom_range(0, 3) + CU_PER_G * $urandom_range(0, 1),
                 $urandom_range(0, 32767), $urandom_range(0, 12),
                 dv, $urandom_range(0, 3) + CU_PER_G * $urandom_range(0, 1),
                 $urandom_range(0, 32767), $urandom_range(0, 12),
                 $urandom_range(0, 3) + CU_PER_G * $urandom_range(0, 1));
         end
         for (int i = 0; i < 10; i++) idle($urandom_range(0, 63));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
